// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, the NOP encoding and the fetch FSM state encoding.
// PC arithmetic lives here so every consumer wraps the PC in the same way.
package instr_fetch_unit_pkg;

  localparam int PC_W    = 26;
  localparam int INSTR_W = 32;

  localparam logic [5:0]         OPC_NOP  = 6'b000000;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WAIT  = 2'b10
  } fetch_state_t;

  // Word PC increment; the carry out of bit PC_W-1 is dropped so the PC wraps silently.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 26'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the word PC, keeps at most one imem request outstanding and
// buffers one instruction for decode, presenting NOP whenever the buffer is empty.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 26'h000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [PC_W-1:0]     instr_pc,
  input  logic                stall,
  input  logic                load_pc,
  input  logic [PC_W-1:0]     load_pc_val
);

  fetch_state_t       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    instr_pc_q;
  logic               valid_q;

  logic               consume_s;
  logic               req_s;
  logic               hs_s;

  // Request is raised only while the buffer is empty or draining without a redirect,
  // so a response never lands on an unconsumed instruction.
  always_comb begin
    consume_s = valid_q & ~stall;
    req_s     = 1'b0;
    case (state_q)
      S_FETCH: req_s = ~valid_q | (~stall & ~load_pc);
      default: req_s = 1'b0;
    endcase
    hs_s = req_s & imem.imem_gnt;
  end

  // Fetch FSM together with the PC and the one-entry instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      instr_pc_q <= 26'h000_0000;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (hs_s) begin
            state_q <= S_WAIT;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            state_q    <= S_FETCH;
            instr_q    <= imem.imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_next(pc_q);
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (consume_s) begin
        valid_q <= 1'b0;
        instr_q <= NOP_WORD;
        if (load_pc) begin
          pc_q <= load_pc_val;
        end
      end
    end
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign instr_pc       = instr_pc_q;

endmodule
